// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter and its return-address stack.
package pc_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } pc_state_t;

  localparam int DEFAULT_RESET_VECTOR = 256;

endpackage

// File: rtl/pc_ras_unit_ras_stack.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest entry.
module ras_stack #(
  parameter int PC_WIDTH  = 12,
  parameter int RAS_DEPTH = 8
) (
  input  logic                clock,
  input  logic                resetCPU,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] push_data,
  output logic [PC_WIDTH-1:0] top,
  output logic                empty,
  output logic                full,
  output logic                overflow,
  output logic                underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] COUNT_ONE = CW'(1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] mem_reg [RAS_DEPTH];
  logic [PW-1:0]       sp_reg;
  logic [CW-1:0]       count_reg;
  logic                empty_reg;
  logic                full_reg;
  logic [PW-1:0]       top_ptr;

  // sp_reg addresses the next free slot, so the newest entry sits one below it.
  assign top_ptr   = sp_reg - PTR_ONE;
  assign top       = mem_reg[top_ptr];
  assign empty     = empty_reg;
  assign full      = full_reg;
  assign overflow  = push & full_reg;
  assign underflow = pop & empty_reg;

  always_ff @(posedge clock) begin
    if (push) begin
      mem_reg[sp_reg] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge resetCPU) begin
    if (!resetCPU) begin
      sp_reg    <= '0;
      count_reg <= '0;
      empty_reg <= 1'b1;
      full_reg  <= 1'b0;
    end else if (push) begin
      sp_reg    <= sp_reg + PTR_ONE;
      empty_reg <= 1'b0;
      if (!full_reg) begin
        count_reg <= count_reg + COUNT_ONE;
        full_reg  <= (count_reg + COUNT_ONE) == DEPTH_C;
      end
    end else if (pop && !empty_reg) begin
      sp_reg    <= top_ptr;
      count_reg <= count_reg - COUNT_ONE;
      full_reg  <= 1'b0;
      empty_reg <= count_reg == COUNT_ONE;
    end
  end

endmodule

// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with return-address stack, stall input and latched halt/resume.
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int PC_WIDTH     = 12,
  parameter int RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int RAS_DEPTH    = 8
) (
  input  logic                clock,
  input  logic                resetCPU,
  input  logic                stall,
  input  logic                HLT,
  input  logic                resume,
  input  logic                zero,
  input  logic                negative,
  input  logic                bzero,
  input  logic                bnegative,
  input  logic                jump,
  input  logic                call,
  input  logic                ret,
  input  logic [PC_WIDTH-1:0] address,
  output logic [PC_WIDTH-1:0] programCounter,
  output logic                halted,
  output logic                rasEmpty,
  output logic                rasFull,
  output logic                rasError
);

  pc_state_t           state_reg;
  logic [PC_WIDTH-1:0] pc_reg;
  logic [PC_WIDTH-1:0] pc_next;
  logic                error_reg;
  logic                run_active;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] branch_add;
  logic                select;
  logic                ras_push;
  logic                ras_pop;
  logic [PC_WIDTH-1:0] ras_top;
  logic                ras_empty;
  logic                ras_full;
  logic                ras_overflow;
  logic                ras_underflow;
  logic                err_event;

  // HLT wins over stall, so a halt request always freezes the PC on its edge.
  assign run_active = (state_reg == RUN) && !HLT && !stall;
  assign pc_inc     = pc_reg + PC_WIDTH'(1);
  assign branch_add = pc_inc + address;
  assign select     = (bzero & zero) | (bnegative & negative);
  assign ras_pop    = run_active & ret;
  assign ras_push   = run_active & call & ~ret;
  assign err_event  = ras_overflow | ras_underflow | (run_active & call & ret);

  ras_stack #(
    .PC_WIDTH (PC_WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clock    (clock),
    .resetCPU (resetCPU),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(pc_inc),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full),
    .overflow (ras_overflow),
    .underflow(ras_underflow)
  );

  always_comb begin
    pc_next = pc_reg;
    if (run_active) begin
      if (ret)         pc_next = ras_empty ? pc_inc : ras_top;
      else if (call)   pc_next = address;
      else if (jump)   pc_next = address;
      else if (select) pc_next = branch_add;
      else             pc_next = pc_inc;
    end
  end

  always_ff @(posedge clock or negedge resetCPU) begin
    if (!resetCPU) begin
      state_reg <= RUN;
      pc_reg    <= PC_WIDTH'(RESET_VECTOR);
      error_reg <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      error_reg <= error_reg | err_event;
      case (state_reg)
        RUN:     if (HLT) state_reg <= HALTED;
        HALTED:  if (resume && !HLT) state_reg <= RUN;
        default: state_reg <= RUN;
      endcase
    end
  end

  assign programCounter = pc_reg;
  assign halted         = (state_reg == HALTED);
  assign rasEmpty       = ras_empty;
  assign rasFull        = ras_full;
  assign rasError       = error_reg;

endmodule
